// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle RV32I-subset core (ADDI/ADD/SUB/LW/SW/BEQ/BNE/JAL)
// sharing one req/ready memory port for instruction fetch and data access.
module multicycle_cpu #(
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  ADDRESS_WIDTH = 5,
    parameter int                  PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  EQOut,
    output logic                  WEnOut,
    output logic                  instr_retired,
    output logic                  halted
);
    localparam int NREGS = 2 ** ADDRESS_WIDTH;
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

    state_t                   state;
    logic [PC_WIDTH-1:0]      pc;
    logic [31:0]              ir;
    logic [DATA_WIDTH-1:0]    a, b, alu_out;
    logic [DATA_WIDTH-1:0]    regs [NREGS];
    logic                     eq_out;

    logic [6:0]               opcode, funct7;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] rs1, rs2, rd;
    logic                     is_addi, is_add, is_sub, is_lw, is_sw, is_beq, is_bne, is_jal, legal;
    logic signed [31:0]       imm;
    logic [DATA_WIDTH-1:0]    imm_d, alu_res, wb_data;
    logic [PC_WIDTH-1:0]      imm_pc, pc_plus4, branch_pc, alu_pc;
    logic                     taken, rf_we;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ADDRESS_WIDTH'(ir[19:15]);
    assign rs2    = ADDRESS_WIDTH'(ir[24:20]);
    assign rd     = ADDRESS_WIDTH'(ir[11:7]);

    assign is_addi = opcode == 7'h13 && funct3 == 3'b000;
    assign is_add  = opcode == 7'h33 && funct3 == 3'b000 && funct7 == 7'h00;
    assign is_sub  = opcode == 7'h33 && funct3 == 3'b000 && funct7 == 7'h20;
    assign is_lw   = opcode == 7'h03 && funct3 == 3'b010;
    assign is_sw   = opcode == 7'h23 && funct3 == 3'b010;
    assign is_beq  = opcode == 7'h63 && funct3 == 3'b000;
    assign is_bne  = opcode == 7'h63 && funct3 == 3'b001;
    assign is_jal  = opcode == 7'h6f;
    assign legal   = is_addi || is_add || is_sub || is_lw || is_sw || is_beq || is_bne || is_jal;

    assign imm = is_jal            ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0}
               : (is_beq || is_bne) ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0}
               : is_sw             ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
               :                     {{20{ir[31]}}, ir[31:20]};
    assign imm_d  = DATA_WIDTH'(imm);
    assign imm_pc = PC_WIDTH'(imm);

    // LW/SW address generation shares the adder with ADDI/ADD
    assign alu_res   = is_sub ? a - b : a + (is_add ? b : imm_d);
    assign pc_plus4  = pc + PC_WIDTH'(4);
    assign branch_pc = (pc + imm_pc) & ALIGN;
    assign alu_pc    = PC_WIDTH'(alu_out);
    assign taken     = is_beq ? a == b : a != b;
    assign rf_we     = state == S_WB || (state == S_EXECUTE && is_jal);
    assign wb_data   = state == S_EXECUTE ? DATA_WIDTH'(pc_plus4) : alu_out;

    assign mem_req       = rst && (state == S_FETCH || state == S_MEM);
    assign mem_we        = state == S_MEM && is_sw;
    assign mem_addr      = (state == S_MEM ? alu_pc : pc) & ALIGN;
    assign mem_wdata     = mem_we ? b : '0;
    assign a0            = regs[10];
    assign EQOut         = eq_out;
    assign WEnOut        = rf_we;
    assign halted        = state == S_TRAP;
    assign instr_retired = state == S_WB
                        || (state == S_EXECUTE && (is_beq || is_bne || is_jal))
                        || (state == S_MEM && is_sw && mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            eq_out  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata[31:0];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a     <= regs[rs1];
                    b     <= regs[rs2];
                    state <= legal ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
                    alu_out <= alu_res;
                    if (is_beq || is_bne) begin
                        eq_out <= a == b;
                        pc     <= taken ? branch_pc : pc_plus4;
                        state  <= S_FETCH;
                    end else if (is_jal) begin
                        pc    <= branch_pc;
                        state <= S_FETCH;
                    end else begin
                        state <= (is_lw || is_sw) ? S_MEM : S_WB;
                    end
                end
                S_MEM: if (mem_ready) begin
                    alu_out <= mem_rdata;
                    pc      <= is_sw ? pc_plus4 : pc;
                    state   <= is_sw ? S_FETCH : S_WB;
                end
                S_WB: begin
                    pc    <= pc_plus4;
                    state <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
            // x0 is never written, so it always reads back as zero
            if (rf_we && rd != '0) regs[rd] <= wb_data;
        end
    end
endmodule
